hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Parametrised successor to the fixed forwarding-unit and staller pair in the 5-stage core.
- Keeps its own shadow pipeline of in-flight writers (stage E up to stage W).
- From that state it generates per-source forward selects, load-use and long-latency stalls, and redirect flush.
- Sits beside the decode stage. The top level wires its outputs to the source-operand muxes, the PC enable, the FD buffer hold/flush and the DE buffer bubble insert.

Parameters:
- REG_BITS, 4, register index width.
- NUM_SRC, 2, number of source operands checked per decoded instruction.
- DEPTH, 3, tracked stages after decode (index 0=E, 1=M, 2=W).
- LOAD_READY, 1, stage index at which load data becomes forwardable.
- RESOLVE_STAGE, 1, stage index at which branch/jump redirects resolve.
- ZERO_HARDWIRED, 0, if 1 then register 0 never matches (no forward, no stall).
- SEL_BITS, 2, forward-select width; must satisfy 2^SEL_BITS > DEPTH.
- CNT_BITS, 16, stall performance counter width.

Ports:
- clk, input, 1, sole clock; rising edge.
- reset_n, input, 1, asynchronous, active-low reset.
- dec_valid, input, 1, decode stage holds a real instruction (not a noop).
- dec_wr_en, input, 1, decoded instruction writes the register file.
- dec_is_load, input, 1, decoded instruction is a load.
- dec_rd, input, REG_BITS, destination register.
- dec_rs, input, NUM_SRC*REG_BITS, source registers; source i occupies bits [i*REG_BITS +: REG_BITS].
- dec_rs_used, input, NUM_SRC, per-source "operand actually read" flag.
- redirect_valid, input, 1, instruction at RESOLVE_STAGE is redirecting the PC this cycle.
- fwd_sel, output, NUM_SRC*SEL_BITS, per source: 0 = regfile, s+1 = forward from stage index s.
- stall, output, 1, hold PC and FD buffer; insert bubble into E.
- flush, output, 1, squash F/D and stages younger than RESOLVE_STAGE.
- inflight_cnt, output, clog2(DEPTH+1), number of valid tracked entries.
- stall_cycles, output, CNT_BITS, saturating count of cycles with stall=1.

Behaviour:
- State is one entry per stage: valid, wr_en, rd, is_load. The "ready" test is stage index >= (is_load ? LOAD_READY : 0).
- Reset (reset_n low, async):
  - all entries invalid; stall_cycles=0;
  - outputs then evaluate to fwd_sel=0, stall=0, flush=0, inflight_cnt=0.
- Match for source i:
  - requires dec_valid & dec_rs_used[i], an entry that is valid & wr_en, and rd == rs[i];
  - excluded when ZERO_HARDWIRED=1 and rs[i]==0.
  - Youngest match (lowest stage index) wins.
- fwd_sel[i] (combinational):
  - youngest match ready -> index+1;
  - no match -> 0;
  - youngest match not ready -> don't-care, driven 0.
- stall (combinational) = any source's youngest match is not ready, and redirect_valid=0.
- flush (combinational) = redirect_valid. Redirect overrides stall in the same cycle.
- Per clock edge:
  - entries shift toward index DEPTH-1; the entry at DEPTH-1 retires.
  - Index 0 loads the decode instruction if dec_valid & !stall & !redirect_valid; otherwise it loads a bubble (valid=0).
  - On redirect_valid, shifted entries landing at indices 1..RESOLVE_STAGE, i.e. those that occupied 0..RESOLVE_STAGE-1, are invalidated.
  - The redirecting instruction itself and older entries survive.
- Stall latency:
  - load-use with LOAD_READY=1 gives exactly 1 stall cycle;
  - a load at index 0 with LOAD_READY=2 gives 2 cycles.
  - Stall never persists longer than LOAD_READY cycles for a single producer.
- stall_cycles increments on each edge where stall=1 and holds at 2^CNT_BITS-1.
- inflight_cnt = popcount of entry valid bits (registered state, not next state).
- Reset asserted mid-stall or mid-redirect clears everything immediately. The first post-reset edge loads decode normally.
- dec_valid=0 never stalls and never forwards.

Test Plan:
- ALU chain: `add r3` issued, then `sub r5,r3,r3` next cycle -> fwd_sel = {2'd1,2'd1}, stall=0. One cycle later the consumer of r3 sees fwd_sel=2 (M).
- Load-use: `lw r4` at E, decode reads r4 -> stall=1 for exactly 1 cycle, a bubble enters E, then fwd_sel=2, stall=0. stall_cycles goes 0->1.
- Priority: r6 written at W (ALU) and again at E (ALU), decode reads r6 -> fwd_sel=1 (E, youngest), not 3.
- Redirect with stall: branch at M asserts redirect_valid while a load-use hazard exists -> flush=1, stall=0. After the edge, index 1 is invalid, the branch is at W, and index 0 holds a bubble.
- ZERO_HARDWIRED=1: `lw r0` at E, decode reads r0 -> stall=0, fwd_sel=0. With ZERO_HARDWIRED=0 -> stall=1.
- Reset/saturation: CNT_BITS=2, force 5 stall cycles -> stall_cycles=3. Drop reset_n mid-stall -> stall_cycles=0, inflight_cnt=0 and stall=0 before the next clk edge.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Hazard control beside decode: tracks in-flight writers E..W and derives operand
// forward selects, load-use stalls, redirect flush and a saturating stall counter.
module hazard_control_unit #(
  parameter int REG_BITS       = 4,
  parameter int NUM_SRC        = 2,
  parameter int DEPTH          = 3,
  parameter int LOAD_READY     = 1,
  parameter int RESOLVE_STAGE  = 1,
  parameter int ZERO_HARDWIRED = 0,
  parameter int SEL_BITS       = 2,
  parameter int CNT_BITS       = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          dec_valid,
  input  logic                          dec_wr_en,
  input  logic                          dec_is_load,
  input  logic [REG_BITS-1:0]           dec_rd,
  input  logic [NUM_SRC*REG_BITS-1:0]   dec_rs,
  input  logic [NUM_SRC-1:0]            dec_rs_used,
  input  logic                          redirect_valid,
  output logic [NUM_SRC*SEL_BITS-1:0]   fwd_sel,
  output logic                          stall,
  output logic                          flush,
  output logic [$clog2(DEPTH+1)-1:0]    inflight_cnt,
  output logic [CNT_BITS-1:0]           stall_cycles
);

  localparam int IC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]    ent_vld;
  logic [DEPTH-1:0]    ent_wr;
  logic [DEPTH-1:0]    ent_load;
  logic [REG_BITS-1:0] ent_rd [DEPTH];

  logic                hazard;
  logic [REG_BITS-1:0] src_reg;
  logic                hit;
  logic                hit_ld;
  logic [SEL_BITS-1:0] hit_idx;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic is_ready(input int idx, input logic ld);
    return idx >= (ld ? LOAD_READY : 0);
  endfunction

  // Scan oldest to youngest so the youngest matching writer is the one kept.
  always_comb begin
    fwd_sel = '0;
    hazard  = 1'b0;
    src_reg = '0;
    hit     = 1'b0;
    hit_ld  = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_reg = dec_rs[i*REG_BITS +: REG_BITS];
      hit     = 1'b0;
      hit_ld  = 1'b0;
      hit_idx = '0;
      if (dec_valid && dec_rs_used[i] && !(ZERO_HARDWIRED != 0 && src_reg == '0)) begin
        for (int s = DEPTH-1; s >= 0; s--) begin
          if (ent_vld[s] && ent_wr[s] && ent_rd[s] == src_reg) begin
            hit     = 1'b1;
            hit_ld  = ent_load[s];
            hit_idx = SEL_BITS'(s);
          end
        end
      end
      if (hit) begin
        if (is_ready(int'(hit_idx), hit_ld))
          fwd_sel[i*SEL_BITS +: SEL_BITS] = hit_idx + 1'b1;
        else
          hazard = 1'b1;
      end
    end
  end

  assign stall = hazard & ~redirect_valid;
  assign flush = redirect_valid;

  always_comb begin
    inflight_cnt = '0;
    for (int s = 0; s < DEPTH; s++)
      inflight_cnt = inflight_cnt + IC_W'(ent_vld[s]);
  end

  // Stage boundary: decode -> E, and E..W shift; redirect kills entries younger than the resolver.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_vld      <= '0;
      stall_cycles <= '0;
    end else begin
      for (int s = 1; s < DEPTH; s++)
        ent_vld[s] <= ent_vld[s-1] & ~(redirect_valid & (s <= RESOLVE_STAGE));
      ent_vld[0] <= dec_valid & ~stall & ~redirect_valid;
      if (stall)
        stall_cycles <= sat_inc(stall_cycles);
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 1; s < DEPTH; s++) begin
      ent_wr[s]   <= ent_wr[s-1];
      ent_load[s] <= ent_load[s-1];
      ent_rd[s]   <= ent_rd[s-1];
    end
    ent_wr[0]   <= dec_wr_en;
    ent_load[0] <= dec_is_load;
    ent_rd[0]   <= dec_rd;
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed hazard scenarios then random traffic,
// two parameterisations driven in lockstep against a stage-list reference model.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       dec_valid, dec_wr_en, dec_is_load;
  logic [3:0] dec_rd;
  logic [7:0] dec_rs;
  logic [1:0] dec_rs_used;
  logic       redirect_valid;

  logic [3:0]  fwd_a, fwd_b;
  logic        stall_a, stall_b, flush_a, flush_b;
  logic [1:0]  inf_a, inf_b;
  logic [15:0] sc_a;
  logic [1:0]  sc_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per configuration, list of in-flight instructions by stage.
  bit mv [2][3];
  bit mw [2][3];
  bit ml [2][3];
  int mr [2][3];
  int mcnt [2];
  int zh [2]   = '{0, 1};
  int lr [2]   = '{1, 2};
  int cmax [2] = '{65535, 3};

  hazard_control_unit dut (
    .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid), .dec_wr_en(dec_wr_en),
    .dec_is_load(dec_is_load), .dec_rd(dec_rd), .dec_rs(dec_rs), .dec_rs_used(dec_rs_used),
    .redirect_valid(redirect_valid), .fwd_sel(fwd_a), .stall(stall_a), .flush(flush_a),
    .inflight_cnt(inf_a), .stall_cycles(sc_a)
  );

  hazard_control_unit #(.ZERO_HARDWIRED(1), .CNT_BITS(2), .LOAD_READY(2)) dut_z (
    .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid), .dec_wr_en(dec_wr_en),
    .dec_is_load(dec_is_load), .dec_rd(dec_rd), .dec_rs(dec_rs), .dec_rs_used(dec_rs_used),
    .redirect_valid(redirect_valid), .fwd_sel(fwd_b), .stall(stall_b), .flush(flush_b),
    .inflight_cnt(inf_b), .stall_cycles(sc_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_dec(input logic v, input logic w, input logic ld, input int rd,
                         input int rs1, input int rs0, input logic [1:0] used, input logic rdr);
    dec_valid      = v;
    dec_wr_en      = w;
    dec_is_load    = ld;
    dec_rd         = 4'(rd);
    dec_rs         = {4'(rs1), 4'(rs0)};
    dec_rs_used    = used;
    redirect_valid = rdr;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mcnt[m] = 0;
      for (int s = 0; s < 3; s++) mv[m][s] = 1'b0;
    end
  endtask

  task automatic model_eval(input int m, output logic [3:0] sel, output logic stl);
    logic hz;
    int   rs;
    int   best;
    hz  = 1'b0;
    sel = '0;
    for (int i = 0; i < 2; i++) begin
      rs   = int'(dec_rs[i*4 +: 4]);
      best = -1;
      if (dec_valid && dec_rs_used[i] && !(zh[m] != 0 && rs == 0))
        for (int s = 0; s < 3; s++)
          if (best < 0 && mv[m][s] && mw[m][s] && mr[m][s] == rs) best = s;
      if (best >= 0) begin
        if (best >= (ml[m][best] ? lr[m] : 0)) sel[i*2 +: 2] = 2'(best + 1);
        else hz = 1'b1;
      end
    end
    stl = hz && !redirect_valid;
  endtask

  task automatic model_edge();
    logic [3:0] sel;
    logic       stl;
    for (int m = 0; m < 2; m++) begin
      model_eval(m, sel, stl);
      for (int s = 2; s >= 1; s--) begin
        mv[m][s] = mv[m][s-1] && !(redirect_valid && s <= 1);
        mw[m][s] = mw[m][s-1];
        ml[m][s] = ml[m][s-1];
        mr[m][s] = mr[m][s-1];
      end
      mv[m][0] = dec_valid && !stl && !redirect_valid;
      mw[m][0] = dec_wr_en;
      ml[m][0] = dec_is_load;
      mr[m][0] = int'(dec_rd);
      if (stl && mcnt[m] < cmax[m]) mcnt[m]++;
    end
  endtask

  task automatic check_all();
    logic [3:0] sel;
    logic       stl;
    int         pop;
    for (int m = 0; m < 2; m++) begin
      model_eval(m, sel, stl);
      pop = int'(mv[m][0]) + int'(mv[m][1]) + int'(mv[m][2]);
      chk($sformatf("cfg%0d.fwd_sel", m), (m == 0) ? 32'(fwd_a) : 32'(fwd_b), 32'(sel));
      chk($sformatf("cfg%0d.stall", m), (m == 0) ? 32'(stall_a) : 32'(stall_b), 32'(stl));
      chk($sformatf("cfg%0d.flush", m), (m == 0) ? 32'(flush_a) : 32'(flush_b), 32'(redirect_valid));
      chk($sformatf("cfg%0d.inflight", m), (m == 0) ? 32'(inf_a) : 32'(inf_b), 32'(pop));
      chk($sformatf("cfg%0d.stall_cycles", m), (m == 0) ? 32'(sc_a) : 32'(sc_b), 32'(mcnt[m]));
    end
  endtask

  task automatic cycle();
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      set_dec(0, 0, 0, 0, 0, 0, 2'b00, 0);
      cycle();
    end
  endtask

  initial begin
    reset_n = 1'b1;
    set_dec(0, 0, 0, 0, 0, 0, 2'b00, 0);
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("reset.stall_cycles", 32'(sc_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // ALU chain: add r3 then sub r5,r3,r3, then a later consumer of r3
    set_dec(1, 1, 0, 3, 1, 2, 2'b11, 0);
    cycle();
    set_dec(1, 1, 0, 5, 3, 3, 2'b11, 0);
    #1;
    chk("alu.fwd_both_E", 32'(fwd_a), 32'h5);
    chk("alu.no_stall", 32'(stall_a), 32'd0);
    cycle();
    set_dec(1, 1, 0, 7, 3, 9, 2'b11, 0);
    #1;
    chk("alu.fwd_from_M", 32'(fwd_a[3:2]), 32'd2);
    cycle();

    // Load-use
    drain(3);
    set_dec(1, 1, 1, 4, 0, 0, 2'b00, 0);
    cycle();
    set_dec(1, 1, 0, 8, 1, 4, 2'b01, 0);
    #1;
    chk("lduse.stall", 32'(stall_a), 32'd1);
    chk("lduse.cnt_before", 32'(sc_a), 32'd0);
    cycle();
    #1;
    chk("lduse.fwd_M", 32'(fwd_a[1:0]), 32'd2);
    chk("lduse.released", 32'(stall_a), 32'd0);
    chk("lduse.cnt_after", 32'(sc_a), 32'd1);
    chk("lduse.lr2_still", 32'(stall_b), 32'd1);
    cycle();
    cycle();

    // Priority: r6 at W and at E
    drain(3);
    set_dec(1, 1, 0, 6, 0, 0, 2'b00, 0);
    cycle();
    drain(1);
    set_dec(1, 1, 0, 6, 0, 0, 2'b00, 0);
    cycle();
    set_dec(1, 1, 0, 10, 1, 6, 2'b01, 0);
    #1;
    chk("prio.youngest", 32'(fwd_a[1:0]), 32'd1);
    cycle();

    // Redirect overriding a load-use stall
    drain(3);
    set_dec(1, 0, 0, 0, 0, 0, 2'b00, 0);
    cycle();
    set_dec(1, 1, 1, 2, 0, 0, 2'b00, 0);
    cycle();
    set_dec(1, 1, 0, 11, 1, 2, 2'b01, 1);
    #1;
    chk("redir.flush", 32'(flush_a), 32'd1);
    chk("redir.stall_masked", 32'(stall_a), 32'd0);
    cycle();
    set_dec(0, 0, 0, 0, 0, 0, 2'b00, 0);
    #1;
    chk("redir.inflight", 32'(inf_a), 32'd1);
    cycle();

    // Register zero
    drain(3);
    set_dec(1, 1, 1, 0, 0, 0, 2'b00, 0);
    cycle();
    set_dec(1, 1, 0, 12, 1, 0, 2'b01, 0);
    #1;
    chk("zero.stall_normal", 32'(stall_a), 32'd1);
    chk("zero.stall_hw", 32'(stall_b), 32'd0);
    chk("zero.fwd_hw", 32'(fwd_b), 32'd0);
    cycle();
    cycle();

    // Saturation of the narrow counter
    for (int k = 0; k < 3; k++) begin
      drain(2);
      set_dec(1, 1, 1, 4, 0, 0, 2'b00, 0);
      cycle();
      set_dec(1, 1, 0, 13, 4, 1, 2'b10, 0);
      repeat (3) cycle();
    end
    #1;
    chk("sat.cnt", 32'(sc_b), 32'd3);

    // Reset dropped in the middle of a stall
    drain(3);
    set_dec(1, 1, 1, 4, 0, 0, 2'b00, 0);
    cycle();
    set_dec(1, 1, 0, 14, 4, 4, 2'b11, 0);
    #1;
    chk("rst.pre_stall", 32'(stall_a), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst.stall_a", 32'(stall_a), 32'd0);
    chk("rst.stall_b", 32'(stall_b), 32'd0);
    chk("rst.inflight", 32'(inf_a), 32'd0);
    chk("rst.cnt_a", 32'(sc_a), 32'd0);
    chk("rst.cnt_b", 32'(sc_b), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    set_dec(1, 1, 0, 9, 0, 0, 2'b00, 0);
    cycle();
    set_dec(0, 0, 0, 0, 0, 0, 2'b00, 0);
    #1;
    chk("rst.first_edge_loads", 32'(inf_a), 32'd1);
    cycle();

    // Random traffic on a small register subset to keep hazards frequent
    repeat (400) begin
      set_dec(($urandom_range(3) != 0), 1'($urandom), 1'($urandom),
              int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)),
              2'($urandom), ($urandom_range(7) == 0));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
